// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory. The fetch stage drives the request side (master);
// the memory model or cache drives the response side (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC stage feeding the MIPS decoder.
// Holds the PC, fetches one word per instruction over the imem handshake,
// latches the instruction for the decoder and, on retire, advances the PC
// by fallthrough, branch, jump or jump-register. Exceptions and
// misaligned targets redirect to the exception vector.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
    input  logic                clock,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [31:0]         inst,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    output logic                inst_valid,
    input  logic [1:0]          control_type,
    input  logic                take_branch,
    input  logic [31:0]         rs_data,
    input  logic                except_in,
    input  logic                done,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                addr_fault,
    output logic [31:0]         inst_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] CT_FALL   = 2'b00;
    localparam logic [1:0] CT_BRANCH = 2'b01;
    localparam logic [1:0] CT_JUMP   = 2'b10;
    localparam logic [1:0] CT_JR     = 2'b11;

    state_t      state;
    state_t      next_state;
    logic        load_inst;
    logic        retire;
    logic [31:0] branch_offset;
    logic [31:0] candidate_pc;
    logic        misaligned;
    logic [31:0] next_pc;

    // Decoder-facing fields are simple slices of the held instruction, so
    // they can only change when the instruction register loads.
    assign opcode    = inst[31:26];
    assign funct     = inst[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign imem.imem_addr = pc;

    // State register: reset always returns to FETCH, even mid-WAIT, so a
    // late response from memory is simply never looked at.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs: one request cycle, wait without a
    // timeout, then hold the instruction until execute retires it.
    always_comb begin
        next_state    = state;
        imem.imem_req = 1'b0;
        inst_valid    = 1'b0;
        load_inst     = 1'b0;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                next_state    = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_valid) begin
                    load_inst  = 1'b1;
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (done) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Next-PC selection. The exception wins over everything; a misaligned
    // candidate (only reachable through jr) is redirected to the vector and
    // flagged as an address fault during the retire cycle only.
    always_comb begin
        branch_offset = {{14{inst[15]}}, inst[15:0], 2'b00};
        candidate_pc  = pc_plus4;
        case (control_type)
            CT_FALL:   candidate_pc = pc_plus4;
            CT_BRANCH: candidate_pc = take_branch ? (pc_plus4 + branch_offset) : pc_plus4;
            CT_JUMP:   candidate_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
            CT_JR:     candidate_pc = rs_data;
            default:   candidate_pc = pc_plus4;
        endcase
        misaligned = (candidate_pc[1:0] != 2'b00);
        if (except_in) begin
            next_pc = EXC_VECTOR;
        end else if (misaligned) begin
            next_pc = EXC_VECTOR;
        end else begin
            next_pc = candidate_pc;
        end
        addr_fault = retire && !except_in && misaligned;
    end

    // Architectural state: instruction register loads on the WAIT->EXEC
    // edge; PC and retired count move only on a retire edge. Both the PC
    // and the counter wrap naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_count <= 32'h0;
        end else begin
            if (load_inst) begin
                inst <= imem.imem_rdata;
            end
            if (retire) begin
                pc         <= next_pc;
                inst_count <= inst_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: walks fallthrough, branch,
// jump, jr (aligned and misaligned), exception priority, reset during a
// pending fetch, a long execute hold and PC wrap-around.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h00400000;
    localparam logic [31:0] EXC_VECTOR = 32'h80000180;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        inst_valid;
    logic [1:0]  control_type = 2'b00;
    logic        take_branch = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic        except_in = 1'b0;
    logic        done = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_fault;
    logic [31:0] inst_count;

    int          compared = 0;
    int          mismatched = 0;
    int          req_count = 0;
    int          fault_count = 0;
    int          req_base;
    int          fault_base;
    logic [31:0] exp_count;
    logic        fault_pre;
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem         (bus),
        .inst         (inst),
        .opcode       (opcode),
        .funct        (funct),
        .inst_valid   (inst_valid),
        .control_type (control_type),
        .take_branch  (take_branch),
        .rs_data      (rs_data),
        .except_in    (except_in),
        .done         (done),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .addr_fault   (addr_fault),
        .inst_count   (inst_count)
    );

    always #5 clock = ~clock;

    // Mid-cycle pulse counters for imem_req and addr_fault.
    always @(negedge clock) begin
        if (bus.imem_req) req_count++;
        if (addr_fault) fault_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Starting in FETCH: the request cycle, then latency WAIT cycles with
    // the response on the last of them; ends in EXEC.
    task automatic do_fetch(input logic [31:0] word, input int latency);
        tick();
        repeat (latency - 1) tick();
        bus.imem_valid = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    // Retire the held instruction; fault_pre captures addr_fault during
    // the retire cycle, before the edge.
    task automatic retire(input logic [1:0] ct, input logic tk, input logic [31:0] rs, input logic exc);
        control_type = ct;
        take_branch  = tk;
        rs_data      = rs;
        except_in    = exc;
        done         = 1'b1;
        #1;
        fault_pre = addr_fault;
        @(posedge clock);
        #1;
        done         = 1'b0;
        control_type = 2'b00;
        take_branch  = 1'b0;
        rs_data      = 32'h0;
        except_in    = 1'b0;
        exp_count    = exp_count + 32'd1;
    endtask

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_count      = 32'h0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        req_base = req_count;
        check("reset_pc", pc, RESET_PC);
        check("reset_inst", inst, 32'h0);
        check("reset_count", inst_count, 32'h0);
        check("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("reset_addr_fault", {31'b0, addr_fault}, 32'h0);
        check("first_req", {31'b0, bus.imem_req}, 32'h1);
        check("first_addr", bus.imem_addr, RESET_PC);

        // Fallthrough with 2-cycle memory latency, done after one hold cycle
        do_fetch(32'h00851020, 2);
        check("ft_inst", inst, 32'h00851020);
        check("ft_opcode", {26'b0, opcode}, 32'h0);
        check("ft_funct", {26'b0, funct}, 32'h20);
        check("ft_inst_valid", {31'b0, inst_valid}, 32'h1);
        check("ft_pc_hold", pc, 32'h00400000);
        check("ft_pc_plus4", pc_plus4, 32'h00400004);
        tick();
        retire(2'b00, 1'b0, 32'h0, 1'b0);
        check("ft_pc", pc, 32'h00400004);
        check("ft_count", inst_count, exp_count);
        check("ft_req_once", req_count - req_base, 32'd1);
        check("ft_inst_valid_off", {31'b0, inst_valid}, 32'h0);

        // Jump to 0x00400010, then taken branch with imm -4
        do_fetch(32'h08100004, 1);
        retire(2'b10, 1'b0, 32'h0, 1'b0);
        check("j_to_10", pc, 32'h00400010);
        do_fetch(32'h1000FFFC, 1);
        retire(2'b01, 1'b1, 32'h0, 1'b0);
        check("br_taken", pc, 32'h00400004);

        // Back to 0x00400010, branch not taken
        do_fetch(32'h08100004, 1);
        retire(2'b10, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h1000FFFC, 1);
        retire(2'b01, 1'b0, 32'h0, 1'b0);
        check("br_not_taken", pc, 32'h00400014);

        // Jump, aligned jr, misaligned jr
        do_fetch(32'h08100008, 1);
        retire(2'b10, 1'b0, 32'h0, 1'b0);
        check("jump", pc, 32'h00400020);
        do_fetch(32'h03E00008, 1);
        retire(2'b11, 1'b0, 32'h00400100, 1'b0);
        check("jr_aligned", pc, 32'h00400100);
        check("jr_aligned_nofault", {31'b0, fault_pre}, 32'h0);
        fault_base = fault_count;
        do_fetch(32'h03E00008, 1);
        retire(2'b11, 1'b0, 32'h00400102, 1'b0);
        check("jr_misaligned_pc", pc, EXC_VECTOR);
        check("jr_fault_pulse", {31'b0, fault_pre}, 32'h1);
        check("jr_fault_after", {31'b0, addr_fault}, 32'h0);
        check("jr_fault_count", fault_count - fault_base, 32'd1);
        check("jr_count", inst_count, exp_count);

        // Exception beats a jump and still counts as retired
        do_fetch(32'h08100004, 1);
        retire(2'b10, 1'b0, 32'h0, 1'b1);
        check("exc_pc", pc, EXC_VECTOR);
        check("exc_count", inst_count, exp_count);

        // Reset while waiting; late response lands in FETCH and is ignored
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 32'h0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        check("rst_wait_req", {31'b0, bus.imem_req}, 32'h1);
        check("rst_wait_pc", pc, RESET_PC);
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        check("rst_wait_inst", inst, 32'h0);
        check("rst_wait_count", inst_count, 32'h0);
        check("rst_wait_not_exec", {31'b0, inst_valid}, 32'h0);
        check("rst_wait_no_req", {31'b0, bus.imem_req}, 32'h0);

        // Complete that fetch, then hold done low for 10 cycles
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h012A4020;
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        held_pc   = pc;
        held_inst = inst;
        req_base  = req_count;
        repeat (10) tick();
        check("hold_pc", pc, RESET_PC);
        check("hold_pc_same", pc, held_pc);
        check("hold_inst", inst, 32'h012A4020);
        check("hold_inst_same", inst, held_inst);
        check("hold_inst_valid", {31'b0, inst_valid}, 32'h1);
        check("hold_no_req", req_count - req_base, 32'd0);

        // Wrap: jr to 0xFFFFFFFC, then fallthrough to 0
        retire(2'b11, 1'b0, 32'hFFFFFFFC, 1'b0);
        check("wrap_pc", pc, 32'hFFFFFFFC);
        check("wrap_addr", bus.imem_addr, 32'hFFFFFFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        do_fetch(32'h00000000, 1);
        retire(2'b00, 1'b0, 32'h0, 1'b0);
        check("wrap_pc_zero", pc, 32'h0);
        check("wrap_count", inst_count, exp_count);
        check("wrap_no_fault", {31'b0, fault_pre}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and next-PC stage that sits directly upstream of the MIPS decoder. It holds the program counter and issues word requests to instruction memory over a request/valid handshake. It latches the returned instruction and presents its opcode and funct fields to the decoder. When the execute stage signals completion, it advances the PC using the decoder's control_type, the branch outcome, the jump target or a register value, with exceptions and misaligned targets redirected to the exception vector.

## Interface
Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset.
- EXC_VECTOR, 32'h80000180, PC loaded on exception or misaligned target.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  one-cycle pulse requesting the word at imem_addr.
- imem_addr  output  32  fetch address; equals pc.
- imem_valid  input  1  imem_rdata valid this cycle; arrives at least 1 cycle after imem_req.
- imem_rdata  input  32  fetched instruction word.
- inst  output  32  latched instruction register.
- opcode  output  6  inst[31:26], to decoder.
- funct  output  6  inst[5:0], to decoder.
- inst_valid  output  1  inst is held and being executed.
- control_type  input  2  from decoder: 00 fallthrough, 01 branch, 10 jump, 11 jump register.
- take_branch  input  1  branch condition met (beq/bne resolved downstream).
- rs_data  input  32  register rs value, used for jr.
- except_in  input  1  decoder/execute exception for the current instruction.
- done  input  1  execute stage retires the current instruction this cycle.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, combinational.
- addr_fault  output  1  one-cycle pulse: a computed target was misaligned.
- inst_count  output  32  retired instruction counter.

## Operation
- FSM states: S_FETCH, S_WAIT, S_EXEC.
- S_FETCH: imem_req=1 for exactly this cycle with imem_addr=pc; next state S_WAIT.
- S_WAIT: imem_req=0; on imem_valid, inst<=imem_rdata and go to S_EXEC; otherwise stay, with no timeout.
- S_EXEC: inst_valid=1; inst is stable. When done=1: pc<=next_pc, inst_count<=inst_count+1, go to S_FETCH. If done=0, hold.
- done, control_type, take_branch, rs_data and except_in are sampled only in S_EXEC and are ignored elsewhere.
- imem_valid is ignored outside S_WAIT.
- next_pc, in priority order:
  - except_in=1 -> EXC_VECTOR.
  - control_type=00 -> pc_plus4.
  - control_type=01 -> take_branch ? pc_plus4 + (sign-extended inst[15:0] << 2) : pc_plus4.
  - control_type=10 -> {pc_plus4[31:28], inst[25:0], 2'b00}.
  - control_type=11 -> rs_data.
- Misaligned target: if the candidate next_pc[1:0]≠0 (possible only via jr), next_pc is EXC_VECTOR instead and addr_fault pulses in the retire cycle.
- Arithmetic is 32-bit modulo 2^32. pc_plus4 wraps from 32'hFFFFFFFC to 0, and branch targets wrap likewise, with no fault.
- inst_count wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset values: state=S_FETCH, pc=RESET_PC, inst=0, inst_count=0, inst_valid=0, addr_fault=0. The first imem_req is asserted in the first cycle after reset deasserts.
- Minimum 3 cycles per instruction: FETCH, WAIT with imem_valid in the same cycle, then EXEC with done=1. Each extra cycle of memory latency or withheld done adds 1 cycle.
- opcode, funct and inst change only on the S_WAIT→S_EXEC edge.
- pc changes only on a retire edge or on reset.
- Reset asserted in any state, including mid-WAIT, overrides everything. A late imem_valid after reset lands in S_FETCH and is ignored. No done is counted in the reset cycle.
- done and except_in high together in S_EXEC: the instruction retires to EXC_VECTOR and inst_count increments.

## Test plan
- Fallthrough: reset; memory returns 32'h00851020 with 2-cycle latency, control_type=00, done after 1 cycle -> pc goes 32'h00400000→32'h00400004, inst_count=1, imem_req pulses once per instruction.
- Branch: pc=32'h00400010, inst imm16=16'hFFFC, control_type=01. With take_branch=1 -> pc=32'h00400004; with take_branch=0 -> pc=32'h00400014.
- Jump and jr: inst[25:0]=26'h0100008, control_type=10 -> pc=32'h00400020. control_type=11 with rs_data=32'h00400100 -> pc=32'h00400100. With rs_data=32'h00400102 -> pc=32'h80000180 and a single addr_fault pulse.
- Exception priority: control_type=10 with except_in=1 and done=1 -> pc=32'h80000180, inst_count increments.
- Reset mid-WAIT: reset in S_WAIT, then imem_valid arrives one cycle after reset -> value ignored, pc=32'h00400000, a fresh imem_req is issued, inst stays 0.
- Hold and wrap: done held 0 for 10 cycles -> pc, inst and inst_valid stable, no imem_req. pc=32'hFFFFFFFC with fallthrough -> pc=0.
